// File: rtl/readout_seq.sv
// Readout sequencer: streams captured samples newest-first from sample memory
// to the host transmit stream, with per-byte-group disable masking.
module readout_seq #(
  parameter int unsigned MDW = 32,
  parameter int unsigned AW  = 12,
  parameter int unsigned CW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     cmd_code,
  input  logic [31:0]    cmd_data,
  input  logic           cmd_valid,
  input  logic           abort,
  input  logic           start,
  input  logic [AW-1:0]  trg_addr,
  output logic           mem_rd,
  output logic [AW-1:0]  mem_addr,
  input  logic [MDW-1:0] mem_rdata,
  output logic           out_tvalid,
  output logic [MDW-1:0] out_tdata,
  output logic [3:0]     out_tkeep,
  input  logic           out_tready,
  output logic           busy,
  output logic           done
);

  localparam int unsigned NGRP     = MDW / 8;
  localparam logic [7:0]  CMD_CFG  = 8'h81;
  localparam logic [7:0]  CMD_MASK = 8'h82;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_LAT  = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  read_cnt_q, read_cnt_d;
  logic [CW-1:0]  delay_cnt_q, delay_cnt_d;
  logic [3:0]     mask_q, mask_d;
  logic [CW-1:0]  rem_q, rem_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [3:0]     keep_q, keep_d;
  logic [MDW-1:0] data_q, data_d;
  logic           mem_rd_q, mem_rd_d;
  logic           tvalid_q, tvalid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      read_cnt_q  <= '0;
      delay_cnt_q <= '0;
      mask_q      <= '0;
      rem_q       <= '0;
      addr_q      <= '0;
      keep_q      <= '0;
      data_q      <= '0;
      mem_rd_q    <= 1'b0;
      tvalid_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      read_cnt_q  <= read_cnt_d;
      delay_cnt_q <= delay_cnt_d;
      mask_q      <= mask_d;
      rem_q       <= rem_d;
      addr_q      <= addr_d;
      keep_q      <= keep_d;
      data_q      <= data_d;
      mem_rd_q    <= mem_rd_d;
      tvalid_q    <= tvalid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state, config decode and registered-output precompute
  always_comb begin
    state_d     = state_q;
    read_cnt_d  = read_cnt_q;
    delay_cnt_d = delay_cnt_q;
    mask_d      = mask_q;
    rem_d       = rem_q;
    addr_d      = addr_q;
    keep_d      = keep_q;
    data_d      = data_q;
    done_d      = 1'b0;

    if (cmd_valid) begin
      case (cmd_code)
        CMD_CFG: begin
          read_cnt_d  = cmd_data[CW-1:0];
          delay_cnt_d = CW'(cmd_data[31:16]);
        end
        CMD_MASK: mask_d = cmd_data[5:2];
        default:  ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        // Snapshot uses pre-write config, so a same-cycle command affects the next run
        if (start) begin
          state_d = S_RD;
          addr_d  = trg_addr + AW'(delay_cnt_q);
          rem_d   = read_cnt_q;
          keep_d  = ~mask_q;
        end
      end
      S_RD:   state_d = S_LAT;
      S_LAT: begin
        for (int g = 0; g < NGRP; g++) begin
          data_d[8*g +: 8] = keep_q[g] ? mem_rdata[8*g +: 8] : 8'h00;
        end
        state_d = S_SEND;
      end
      S_SEND: begin
        if (out_tready) begin
          if (rem_q == '0) begin
            state_d = S_DONE;
          end else begin
            rem_d   = rem_q - CW'(1);
            addr_d  = addr_q - AW'(1);
            state_d = S_RD;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // DONE already pulses done, so an abort there must not pulse it again
    if (abort && (state_q != S_IDLE)) begin
      done_d  = (state_q != S_DONE);
      state_d = S_IDLE;
    end

    mem_rd_d = (state_d == S_RD);
    tvalid_d = (state_d == S_SEND);
    busy_d   = (state_d != S_IDLE);
    done_d   = done_d | (state_d == S_DONE);
  end

  assign mem_rd     = mem_rd_q;
  assign mem_addr   = addr_q;
  assign out_tvalid = tvalid_q;
  assign out_tdata  = data_q;
  assign out_tkeep  = keep_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_readout_seq.sv
// Self-checking bench for readout_seq: table of readout runs plus hand-written
// abort, busy-start, reset and backpressure sequences, scored against a memory model.
module tb_readout_seq;

  localparam int unsigned MDW = 32;
  localparam int unsigned AW  = 12;
  localparam int unsigned CW  = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     cmd_code;
  logic [31:0]    cmd_data;
  logic           cmd_valid;
  logic           abort;
  logic           start;
  logic [AW-1:0]  trg_addr;
  logic           mem_rd;
  logic [AW-1:0]  mem_addr;
  logic [MDW-1:0] mem_rdata;
  logic           out_tvalid;
  logic [MDW-1:0] out_tdata;
  logic [3:0]     out_tkeep;
  logic           out_tready;
  logic           busy;
  logic           done;

  readout_seq #(.MDW(MDW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_code(cmd_code), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .abort(abort), .start(start), .trg_addr(trg_addr),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_tvalid(out_tvalid), .out_tdata(out_tdata), .out_tkeep(out_tkeep),
    .out_tready(out_tready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
  } exp_word_t;

  typedef struct {
    logic [15:0] rd;
    logic [15:0] dly;
    logic [3:0]  mask;
    logic [11:0] trg;
    int          stall;
    logic [11:0] exp_first;
    logic [11:0] exp_last;
    logic [3:0]  exp_keep;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [11:0] exp_addr_q[$];
  exp_word_t   exp_w_q[$];
  logic [15:0] m_read = '0;
  logic [15:0] m_delay = '0;
  logic [3:0]  m_mask = '0;
  int          rd_total = 0;
  int          acc_total = 0;
  int          done_total = 0;
  logic [11:0] last_rd_addr = '0;
  logic [31:0] last_acc_data = '0;
  logic [3:0]  last_acc_keep = '0;
  vec_t        vecs[6];

  function automatic logic [31:0] mem_f(input logic [11:0] a);
    if (a == 12'h200) return 32'hAABBCCDD;
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Sample memory: one-cycle read latency, noise when not read
  always @(posedge clk) mem_rdata <= mem_rd ? mem_f(mem_addr) : $urandom();

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] code, input logic [31:0] data);
    cmd_code  = code;
    cmd_data  = data;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    if (code == 8'h81) begin
      m_read  = data[15:0];
      m_delay = data[31:16];
    end else if (code == 8'h82) begin
      m_mask = data[5:2];
    end
  endtask

  task automatic push_expected(input logic [11:0] trg, output int n);
    logic [11:0] a;
    logic [31:0] w;
    a = trg + m_delay[11:0];
    n = int'(m_read) + 1;
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(a);
      w = mem_f(a);
      for (int g = 0; g < 4; g++) if (m_mask[g]) w[g*8 +: 8] = 8'h00;
      exp_w_q.push_back('{data: w, keep: ~m_mask});
      a = a - 12'd1;
    end
  endtask

  task automatic wait_done(input int base_acc, input int base_done, input int n);
    int cyc;
    for (cyc = 0; cyc < 400 && !done; cyc++) tick();
    check("done_seen", 32'(done), 32'd1);
    tick();
    check("done_single", 32'(done), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("words_out", 32'(acc_total - base_acc), 32'(n));
    check("done_count", 32'(done_total - base_done), 32'd1);
    check("exp_left", 32'(exp_w_q.size()), 32'd0);
  endtask

  task automatic do_run(input logic [11:0] trg, input int stall, input logic cmd_with_start,
                        input logic [31:0] cmd_payload, output logic [11:0] first_addr);
    int n, base_acc, base_done, lat;
    push_expected(trg, n);
    base_acc  = acc_total;
    base_done = done_total;
    trg_addr  = trg;
    start     = 1'b1;
    if (cmd_with_start) begin
      cmd_code  = 8'h81;
      cmd_data  = cmd_payload;
      cmd_valid = 1'b1;
    end
    if (stall > 0) out_tready = 1'b0;
    tick();
    start     = 1'b0;
    cmd_valid = 1'b0;
    if (cmd_with_start) begin
      m_read  = cmd_payload[15:0];
      m_delay = cmd_payload[31:16];
    end
    first_addr = mem_addr;
    check("rd_after_start", 32'(mem_rd), 32'd1);
    for (lat = 1; lat < 20 && !out_tvalid; lat++) tick();
    check("latency", 32'(lat), 32'd3);
    for (int s = 0; s < stall; s++) begin
      check("stall_no_rd", 32'(mem_rd), 32'd0);
      tick();
    end
    out_tready = 1'b1;
    wait_done(base_acc, base_done, n);
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from DUT updates
  task automatic monitor_loop();
    logic        prev_stall = 1'b0;
    logic        prev_skip  = 1'b1;
    logic [31:0] prev_data  = '0;
    logic [3:0]  prev_keep  = '0;
    exp_word_t   e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prev_stall && !prev_skip) begin
          check("stall_valid", 32'(out_tvalid), 32'd1);
          check("stall_data", out_tdata, prev_data);
          check("stall_keep", 32'(out_tkeep), 32'(prev_keep));
        end
        if (mem_rd || out_tvalid) check("rd_valid_excl", 32'(mem_rd & out_tvalid), 32'd0);
        if (mem_rd) begin
          check("exp_addr_avail", 32'(exp_addr_q.size() != 0), 32'd1);
          if (exp_addr_q.size() != 0) check("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
          last_rd_addr = mem_addr;
          rd_total++;
        end
        if (out_tvalid && out_tready) begin
          check("exp_word_avail", 32'(exp_w_q.size() != 0), 32'd1);
          if (exp_w_q.size() != 0) begin
            e = exp_w_q.pop_front();
            check("out_tdata", out_tdata, e.data);
            check("out_tkeep", 32'(out_tkeep), 32'(e.keep));
          end
          last_acc_data = out_tdata;
          last_acc_keep = out_tkeep;
          acc_total++;
        end
        if (done) done_total++;
      end
      prev_stall = out_tvalid && !out_tready;
      prev_data  = out_tdata;
      prev_keep  = out_tkeep;
      prev_skip  = abort || rst;
    end
  endtask

  initial begin
    logic [11:0] fa;
    int n, base_acc, base_done, base_rd, seen, cyc;

    vecs[0] = '{16'd3, 16'd2, 4'h0, 12'h100, 0, 12'h102, 12'h0FF, 4'hF, 1'b0, 32'h0};
    vecs[1] = '{16'd2, 16'd0, 4'h0, 12'h001, 0, 12'h001, 12'hFFF, 4'hF, 1'b0, 32'h0};
    vecs[2] = '{16'd1, 16'd0, 4'h0, 12'h050, 5, 12'h050, 12'h04F, 4'hF, 1'b0, 32'h0};
    vecs[3] = '{16'd0, 16'd0, 4'h5, 12'h200, 0, 12'h200, 12'h200, 4'hA, 1'b1, 32'hAA00CC00};
    vecs[4] = '{16'd1, 16'd5, 4'h0, 12'hFFE, 0, 12'h003, 12'h002, 4'hF, 1'b0, 32'h0};
    vecs[5] = '{16'd0, 16'h1001, 4'h8, 12'h010, 2, 12'h011, 12'h011, 4'h7, 1'b0, 32'h0};

    rst = 1'b1; cmd_code = '0; cmd_data = '0; cmd_valid = 1'b0;
    abort = 1'b0; start = 1'b0; trg_addr = '0; out_tready = 1'b1;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tvalid", 32'(out_tvalid), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_tkeep", 32'(out_tkeep), 32'd0);
    check("rst_tdata", out_tdata, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0;
    fork monitor_loop(); join_none
    tick();

    for (int v = 0; v < 6; v++) begin
      send_cmd(8'h81, {vecs[v].dly, vecs[v].rd});
      send_cmd(8'h82, 32'hFFFF_FFC3 | (32'(vecs[v].mask) << 2));
      do_run(vecs[v].trg, vecs[v].stall, 1'b0, 32'h0, fa);
      check($sformatf("v%0d_first_addr", v), 32'(fa), 32'(vecs[v].exp_first));
      check($sformatf("v%0d_last_addr", v), 32'(last_rd_addr), 32'(vecs[v].exp_last));
      check($sformatf("v%0d_keep", v), 32'(last_acc_keep), 32'(vecs[v].exp_keep));
      if (vecs[v].chk_data) check($sformatf("v%0d_data", v), last_acc_data, vecs[v].exp_data);
      tick();
    end

    // Abort in the third SEND, then a full 8-word rerun
    send_cmd(8'h81, 32'h0000_0007);
    send_cmd(8'h82, 32'h0);
    push_expected(12'h080, n);
    base_acc = acc_total; base_done = done_total; base_rd = rd_total;
    trg_addr = 12'h080; start = 1'b1;
    tick();
    start = 1'b0;
    seen = 0;
    for (cyc = 0; cyc < 100 && seen < 3; cyc++) begin
      tick();
      if (out_tvalid) seen++;
    end
    check("abort_reach_send3", 32'(seen), 32'd3);
    out_tready = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0; out_tready = 1'b1;
    check("abort_tvalid", 32'(out_tvalid), 32'd0);
    check("abort_done", 32'(done), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_words", 32'(acc_total - base_acc), 32'd2);
    check("abort_reads", 32'(rd_total - base_rd), 32'd3);
    exp_addr_q.delete(); exp_w_q.delete();
    tick();
    check("abort_done_once", 32'(done_total - base_done), 32'd1);
    check("abort_done_low", 32'(done), 32'd0);
    do_run(12'h500, 0, 1'b0, 32'h0, fa);

    // Start while busy and mid-run config write keep the running count
    send_cmd(8'h81, 32'h0000_0003);
    push_expected(12'h400, n);
    base_acc = acc_total; base_done = done_total;
    trg_addr = 12'h400; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    send_cmd(8'h81, 32'h0000_0001);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(base_acc, base_done, n);
    do_run(12'h410, 0, 1'b0, 32'h0, fa);
    do_run(12'h420, 0, 1'b1, 32'h0000_0000, fa);
    do_run(12'h430, 0, 1'b0, 32'h0, fa);

    // Abort while idle is a no-op
    base_done = done_total;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_done", 32'(done), 32'd0);
    check("idle_abort_busy", 32'(busy), 32'd0);
    tick();
    check("idle_abort_count", 32'(done_total - base_done), 32'd0);

    // Reset mid-run: no done pulse, config returns to zero
    send_cmd(8'h81, 32'h0000_0003);
    send_cmd(8'h82, 32'h0000_003C);
    push_expected(12'h600, n);
    base_done = done_total;
    trg_addr = 12'h600; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstrun_done", 32'(done), 32'd0);
    check("rstrun_busy", 32'(busy), 32'd0);
    check("rstrun_tvalid", 32'(out_tvalid), 32'd0);
    check("rstrun_tkeep", 32'(out_tkeep), 32'd0);
    exp_addr_q.delete(); exp_w_q.delete();
    m_read = '0; m_delay = '0; m_mask = '0;
    repeat (3) tick();
    check("rstrun_done_count", 32'(done_total - base_done), 32'd0);
    do_run(12'h300, 0, 1'b0, 32'h0, fa);
    check("post_rst_first_addr", 32'(fa), 32'h300);
    check("post_rst_keep", 32'(last_acc_keep), 32'hF);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
